// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Control block for a three-stage IF/ID/EXE pipeline. Produces
//             the fetch PC, the stage-register load enables and the stage
//             valid bits. Also handles taken-branch flushes, EXE-result
//             forwarding selects, single-step gating and a count of
//             retired instructions.
//  Ports    : clk, nReset           - clock, asynchronous active-low reset
//             exe_busy              - multi-cycle EXE op stalls the pipe
//             exe_br_taken/target   - branch resolved in EXE
//             exe_we/exe_rd         - EXE register write
//             id_rs1/id_rs2         - ID source registers
//             step_mode/step_req    - single-step control
//             pc, if_id_en, id_exe_en, id_valid, exe_valid,
//             fwd_a, fwd_b, retired, state - outputs
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int WORD_LEN     = 16,
    parameter int REG_ADDR_LEN = 3,
    parameter int RESET_PC     = 0,
    parameter int PC_STEP      = 1,
    parameter int CNT_W        = 16,
    parameter int ZERO_REG     = 1
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    exe_busy,
    input  logic                    exe_br_taken,
    input  logic [WORD_LEN-1:0]     exe_br_target,
    input  logic                    exe_we,
    input  logic [REG_ADDR_LEN-1:0] exe_rd,
    input  logic [REG_ADDR_LEN-1:0] id_rs1,
    input  logic [REG_ADDR_LEN-1:0] id_rs2,
    input  logic                    step_mode,
    input  logic                    step_req,
    output logic [WORD_LEN-1:0]     pc,
    output logic                    if_id_en,
    output logic                    id_exe_en,
    output logic                    id_valid,
    output logic                    exe_valid,
    output logic                    fwd_a,
    output logic                    fwd_b,
    output logic [CNT_W-1:0]        retired,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STEP = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam logic [WORD_LEN-1:0] c_RESET_PC = WORD_LEN'(RESET_PC);
    localparam logic [WORD_LEN-1:0] c_PC_STEP  = WORD_LEN'(PC_STEP);
    localparam logic                c_ZERO_REG = (ZERO_REG != 0);

    logic [WORD_LEN-1:0] r_pc;
    logic                r_id_valid;
    logic                r_exe_valid;
    logic [CNT_W-1:0]    r_retired;
    logic                r_step_req_q;
    state_t              r_state;

    logic w_step_edge;
    logic w_advance;
    logic w_branch;
    logic w_rd_zero;

    // A step request is a rising edge of the level input. A request held high
    // yields a single advance. An edge that lands while EXE is busy is lost,
    // because the delayed copy is updated every cycle regardless of advance.
    assign w_step_edge = step_req & ~r_step_req_q;
    assign w_advance   = ~exe_busy & (~step_mode | w_step_edge);
    // A branch flag on a bubble carries no meaning, so it is qualified by the
    // EXE valid bit.
    assign w_branch    = r_exe_valid & exe_br_taken;
    assign w_rd_zero   = c_ZERO_REG & (exe_rd == '0);

    assign if_id_en  = w_advance;
    assign id_exe_en = w_advance;

    assign fwd_a = r_exe_valid & exe_we & (exe_rd == id_rs1) & ~w_rd_zero;
    assign fwd_b = r_exe_valid & exe_we & (exe_rd == id_rs2) & ~w_rd_zero;

    assign pc        = r_pc;
    assign id_valid  = r_id_valid;
    assign exe_valid = r_exe_valid;
    assign retired   = r_retired;
    assign state     = r_state;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_pc         <= c_RESET_PC;
            r_id_valid   <= 1'b0;
            r_exe_valid  <= 1'b0;
            r_retired    <= '0;
            r_step_req_q <= 1'b0;
            r_state      <= ST_RUN;
        end else begin
            r_step_req_q <= step_req;

            if (exe_busy) begin
                r_state <= ST_BUSY;
            end else if (step_mode) begin
                r_state <= ST_STEP;
            end else begin
                r_state <= ST_RUN;
            end

            // With no advance, everything holds. A branch that is pending
            // behind a busy EXE waits for the first cycle that advances.
            if (w_advance) begin
                if (r_exe_valid) begin
                    r_retired <= r_retired + 1'b1;
                end
                if (w_branch) begin
                    // Flush the two younger instructions fetched on the
                    // wrong path.
                    r_pc        <= exe_br_target;
                    r_id_valid  <= 1'b0;
                    r_exe_valid <= 1'b0;
                end else begin
                    r_pc        <= r_pc + c_PC_STEP;
                    r_id_valid  <= 1'b1;
                    r_exe_valid <= r_id_valid;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Randomised self-checking bench for pipe_ctrl. A driver applies
//             stimulus on the falling edge and queues the expected outputs
//             from a behavioural model. A monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int WL       = 16;
    localparam int RL       = 3;
    localparam int CW       = 4;
    localparam int PC_STEP  = 1;
    localparam int RESET_PC = 0;
    localparam int N_CYC    = 600;

    logic          clk;
    logic          nReset;
    logic          exe_busy;
    logic          exe_br_taken;
    logic [WL-1:0] exe_br_target;
    logic          exe_we;
    logic [RL-1:0] exe_rd;
    logic [RL-1:0] id_rs1;
    logic [RL-1:0] id_rs2;
    logic          step_mode;
    logic          step_req;
    logic [WL-1:0] pc;
    logic          if_id_en;
    logic          id_exe_en;
    logic          id_valid;
    logic          exe_valid;
    logic          fwd_a;
    logic          fwd_b;
    logic [CW-1:0] retired;
    logic [1:0]    state;

    pipe_ctrl #(
        .WORD_LEN     (WL),
        .REG_ADDR_LEN (RL),
        .RESET_PC     (RESET_PC),
        .PC_STEP      (PC_STEP),
        .CNT_W        (CW),
        .ZERO_REG     (1)
    ) u_dut (
        .clk           (clk),
        .nReset        (nReset),
        .exe_busy      (exe_busy),
        .exe_br_taken  (exe_br_taken),
        .exe_br_target (exe_br_target),
        .exe_we        (exe_we),
        .exe_rd        (exe_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .step_mode     (step_mode),
        .step_req      (step_req),
        .pc            (pc),
        .if_id_en      (if_id_en),
        .id_exe_en     (id_exe_en),
        .id_valid      (id_valid),
        .exe_valid     (exe_valid),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .retired       (retired),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int idv;
        int exv;
        int ret;
        int st;
        int adv;
        int fa;
        int fb;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model state, in plain integers.
    int m_pc, m_idv, m_exv, m_ret, m_st, m_stepq;

    task automatic model_reset();
        m_pc = RESET_PC; m_idv = 0; m_exv = 0; m_ret = 0; m_st = 0; m_stepq = 0;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle; sample it
    // mid-low-phase after the driver has settled the inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("pc",        int'(pc),        e.pc);
                chk("id_valid",  int'(id_valid),  e.idv);
                chk("exe_valid", int'(exe_valid), e.exv);
                chk("retired",   int'(retired),   e.ret);
                chk("state",     int'(state),     e.st);
                chk("if_id_en",  int'(if_id_en),  e.adv);
                chk("id_exe_en", int'(id_exe_en), e.adv);
                chk("fwd_a",     int'(fwd_a),     e.fa);
                chk("fwd_b",     int'(fwd_b),     e.fb);
            end
        end
    end

    // Driver and reference model.
    initial begin
        exp_t e;
        int   adv, edge_s, cyc_since_rst, do_rst, tmo;
        nReset = 1'b0; exe_busy = 1'b0; exe_br_taken = 1'b0; exe_br_target = '0;
        exe_we = 1'b0; exe_rd = '0; id_rs1 = '0; id_rs2 = '0;
        step_mode = 1'b0; step_req = 1'b0;
        model_reset();
        cyc_since_rst = 0;
        repeat (2) @(negedge clk);

        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            nReset = 1'b1;
            do_rst = (cyc_since_rst > 40 && $urandom_range(0, 99) < 2) ? 1 : 0;

            if (cyc_since_rst < 6) begin
                // Clean run straight after reset: plain sequential fetch.
                exe_busy = 1'b0; step_mode = 1'b0; exe_br_taken = 1'b0;
            end else begin
                exe_busy     = ($urandom_range(0, 99) < 25);
                exe_br_taken = ($urandom_range(0, 99) < 25);
                if ($urandom_range(0, 99) < 6) step_mode = ~step_mode;
            end
            step_req      = $urandom_range(0, 1) == 1;
            exe_br_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : WL'($urandom);
            exe_we        = $urandom_range(0, 1) == 1;
            exe_rd        = RL'($urandom_range(0, 7));
            id_rs1        = ($urandom_range(0, 1) == 1) ? exe_rd : RL'($urandom_range(0, 7));
            id_rs2        = ($urandom_range(0, 2) == 0) ? exe_rd : RL'($urandom_range(0, 7));

            if (do_rst == 1) begin
                // Asserted away from any rising edge: outputs must drop now.
                nReset = 1'b0;
                model_reset();
            end

            edge_s = (step_req && m_stepq == 0) ? 1 : 0;
            adv    = (!exe_busy && (!step_mode || edge_s == 1) && do_rst == 0) ? 1 : 0;
            e.pc  = m_pc;
            e.idv = m_idv;
            e.exv = m_exv;
            e.ret = m_ret;
            e.st  = m_st;
            e.adv = (!exe_busy && (!step_mode || edge_s == 1)) ? 1 : 0;
            e.fa  = (m_exv == 1 && exe_we && exe_rd == id_rs1 && exe_rd != 0) ? 1 : 0;
            e.fb  = (m_exv == 1 && exe_we && exe_rd == id_rs2 && exe_rd != 0) ? 1 : 0;
            q_exp.push_back(e);

            // Effect of the coming rising edge.
            if (do_rst == 1) begin
                cyc_since_rst = 0;
            end else begin
                cyc_since_rst++;
                m_stepq = step_req ? 1 : 0;
                m_st    = exe_busy ? 2 : (step_mode ? 1 : 0);
                if (adv == 1) begin
                    if (m_exv == 1) m_ret = (m_ret + 1) % (1 << CW);
                    if (m_exv == 1 && exe_br_taken) begin
                        m_pc  = int'(exe_br_target);
                        m_idv = 0;
                        m_exv = 0;
                    end else begin
                        m_pc  = (m_pc + PC_STEP) % (1 << WL);
                        m_exv = m_idv;
                        m_idv = 1;
                    end
                end
            end
        end

        tmo = 0;
        while (q_exp.size() > 0 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        if (q_exp.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
        end
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WORD_LEN, default 16: PC and branch-target width.
REQ-002 Parameter REG_ADDR_LEN, default 3: register-address width.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Parameter PC_STEP, default 1: PC increment per advance.
REQ-005 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-006 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired and never forwarded.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low, with ports clk and nReset.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 nReset  in  1  asynchronous active-low reset.
REQ-010 exe_busy  in  1  multi-cycle EXE operation still in progress.
REQ-011 exe_br_taken  in  1  EXE-stage branch resolved taken.
REQ-012 exe_br_target  in  WORD_LEN  branch destination.
REQ-013 exe_we, exe_rd  in  1, REG_ADDR_LEN  register write enable and destination of the EXE instruction.
REQ-014 id_rs1, id_rs2  in  REG_ADDR_LEN  source registers of the ID instruction.
REQ-015 step_mode, step_req  in  1, 1  single-step enable and step request level.
REQ-016 pc  out  WORD_LEN  fetch address.
REQ-017 if_id_en, id_exe_en  out  1, 1  pipeline-register load enables.
REQ-018 id_valid, exe_valid  out  1, 1  stage valid bits; 0 means bubble.
REQ-019 fwd_a, fwd_b  out  1, 1  select the EXE result instead of the register-file read for rs1/rs2.
REQ-020 retired  out  CNT_W  count of completed valid EXE instructions.
REQ-021 state  out  2  FSM state: RUN=0, STEP=1, BUSY=2.

Function
REQ-022 The block SHALL compute advance = !exe_busy && (!step_mode || step_edge), where step_edge = step_req && !step_req_q and step_req_q is step_req registered every cycle.
REQ-023 if_id_en and id_exe_en SHALL both equal advance, combinationally.
REQ-024 On advance without a taken branch, the block SHALL update pc <= pc + PC_STEP (modulo 2^WORD_LEN), id_valid <= 1 and exe_valid <= id_valid.
REQ-025 On advance with exe_valid && exe_br_taken, the block SHALL update pc <= exe_br_target, id_valid <= 0 and exe_valid <= 0, giving a two-bubble penalty.
REQ-026 exe_br_taken SHALL be ignored while exe_valid=0.
REQ-027 Without advance, pc, id_valid and exe_valid SHALL hold, including when a branch is pending under exe_busy; the branch takes effect on the first cycle that advances.
REQ-028 fwd_a SHALL equal exe_valid && exe_we && (exe_rd==id_rs1) && !(ZERO_REG && exe_rd==0), combinationally; fwd_b is identical with id_rs2.
REQ-029 retired SHALL increment by 1 on every advance with exe_valid=1 and wrap to 0 after 2^CNT_W-1.
REQ-030 FSM, evaluated each cycle:
  - BUSY when exe_busy=1.
  - Else STEP when step_mode=1.
  - Else RUN.
REQ-031 Toggling step_mode mid-run SHALL take effect on the same cycle through the advance equation; no instruction is lost or duplicated.
REQ-032 A step_req held high SHALL produce exactly one advance.
REQ-033 A step_req edge coinciding with exe_busy=1 SHALL be dropped.

Reset
REQ-034 While nReset=0, the block SHALL set pc=RESET_PC, id_valid=0, exe_valid=0, retired=0, step_req_q=0 and state=RUN, asynchronously.
REQ-035 Reset asserted mid-operation SHALL discard any pending branch, busy hold or step request.
REQ-036 The first rising clk edge after release with advance=1 SHALL set pc=RESET_PC+PC_STEP and id_valid=1.

Verification
REQ-037 Reset release, run 4 cycles, defaults -> pc=0,1,2,3,4; id_valid=1 from cycle 1; exe_valid=1 from cycle 2; retired=2 after cycle 4.
REQ-038 exe_valid=1, exe_br_taken=1, exe_br_target=0x0040 -> next cycle pc=0x0040, id_valid=0, exe_valid=0, retired +1; pc=0x0041 one cycle later.
REQ-039 exe_busy=1 for 3 cycles with a taken branch pending -> pc, valids and retired frozen, state=BUSY, enables 0; branch applied on the cycle busy drops.
REQ-040 exe_valid=1, exe_we=1, exe_rd=3, id_rs1=3, id_rs2=0 -> fwd_a=1, fwd_b=0; with exe_rd=0 and id_rs1=0 -> fwd_a=0 (ZERO_REG=1).
REQ-041 step_mode=1, step_req held high for 5 cycles, then low, then high -> exactly two advances; state=STEP throughout.
REQ-042 CNT_W=4, 17 retirements -> retired wraps 15 to 0 and reads 1; nReset pulsed mid-run -> all outputs at reset values immediately, without waiting for clk.
